// File: rtl/brc_pkg.sv
// rtl/brc_pkg.sv - shared types for the iterative branch comparator
package brc_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } brc_state_e;

endpackage

// File: rtl/brc_chunk_sub.sv
// rtl/brc_chunk_sub.sv - one CHUNK-bit slice of a + ~b + cin
module brc_chunk_sub #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_cout
);

    logic [CHUNK:0] sum;

    assign sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_diff = sum[CHUNK-1:0];
    assign o_cout = sum[CHUNK];

endmodule

// File: rtl/brc_iter.sv
// rtl/brc_iter.sv - chunk-serial branch comparator (BEQ/BNE/BLT/BGE/BLTU/BGEU)
module brc_iter
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_less,
    output logic             o_equal,
    output logic             o_taken,
    output logic             o_illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    brc_state_e       state_q, state_d;
    logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             carry_q, carry_d;
    logic [CHUNK-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             less_q, less_d, equal_q, equal_d;
    logic             taken_q, taken_d, illegal_q, illegal_d;

    logic [WIDTH-1:0] rs1_shr, rs2_shr;
    logic [CHUNK-1:0] a_chunk, b_chunk, diff_chunk, acc_next;
    logic             chunk_cout, last_chunk, overflow, less_now, equal_now;

    // Operands shift right each BUSY cycle so the current chunk always sits at bit 0.
    generate
        if (NCHUNK > 1) begin : g_shift
            assign rs1_shr = {{CHUNK{1'b0}}, rs1_q[WIDTH-1:CHUNK]};
            assign rs2_shr = {{CHUNK{1'b0}}, rs2_q[WIDTH-1:CHUNK]};
        end else begin : g_noshift
            assign rs1_shr = rs1_q;
            assign rs2_shr = rs2_q;
        end
    endgenerate

    assign a_chunk    = rs1_q[CHUNK-1:0];
    assign b_chunk    = rs2_q[CHUNK-1:0];
    assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

    brc_chunk_sub #(.CHUNK(CHUNK)) u_chunk (
        .i_a    (a_chunk),
        .i_b    (b_chunk),
        .i_cin  (carry_q),
        .o_diff (diff_chunk),
        .o_cout (chunk_cout)
    );

    // On the last chunk the bit-0-aligned slice holds the operand and difference MSBs.
    assign acc_next  = acc_q | (a_chunk ^ b_chunk);
    assign equal_now = ~|acc_next;
    assign overflow  = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1]) & (diff_chunk[CHUNK-1] ^ a_chunk[CHUNK-1]);
    assign less_now  = funct3_q[1] ? ~chunk_cout : (diff_chunk[CHUNK-1] ^ overflow);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)    state_d = ST_BUSY;
            ST_BUSY: if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (i_ready)    state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_valid = (state_q == ST_DONE);
    end

    always_comb begin
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct3_d  = funct3_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        less_d    = less_q;
        equal_d   = equal_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        if (state_q == ST_IDLE && i_valid) begin
            rs1_d    = i_rs1_data;
            rs2_d    = i_rs2_data;
            funct3_d = i_funct3;
            carry_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == ST_BUSY) begin
            rs1_d   = rs1_shr;
            rs2_d   = rs2_shr;
            carry_d = chunk_cout;
            acc_d   = acc_next;
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
                less_d    = less_now;
                equal_d   = equal_now;
                illegal_d = (funct3_q[2:1] == 2'b01);
                case (funct3_q)
                    BR_BEQ:           taken_d = equal_now;
                    BR_BNE:           taken_d = ~equal_now;
                    BR_BLT, BR_BLTU:  taken_d = less_now;
                    BR_BGE, BR_BGEU:  taken_d = ~less_now;
                    default:          taken_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            carry_q   <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct3_q  <= funct3_d;
            carry_q   <= carry_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_less    = less_q;
    assign o_equal   = equal_q;
    assign o_taken   = taken_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_brc_iter.sv
// tb/tb_brc_iter.sv - directed and random checks of brc_iter at CHUNK 8, 1 and 32
module tb_brc_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        rdy_in;
    logic [31:0] rs1, rs2;
    logic [2:0]  f3;

    logic o_ready [3];
    logic o_valid [3];
    logic o_less [3];
    logic o_equal [3];
    logic o_taken [3];
    logic o_illegal [3];

    int checks   = 0;
    int failures = 0;

    localparam int NCH [3] = '{4, 32, 1};

    always #5 clk = ~clk;

    brc_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready[0]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(o_valid[0]),
        .i_ready(rdy_in), .o_less(o_less[0]), .o_equal(o_equal[0]),
        .o_taken(o_taken[0]), .o_illegal(o_illegal[0])
    );

    brc_iter #(.WIDTH(32), .CHUNK(1)) dut_c1 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready[1]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(o_valid[1]),
        .i_ready(rdy_in), .o_less(o_less[1]), .o_equal(o_equal[1]),
        .o_taken(o_taken[1]), .o_illegal(o_illegal[1])
    );

    brc_iter #(.WIDTH(32), .CHUNK(32)) dut_c32 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready[2]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(o_valid[2]),
        .i_ready(rdy_in), .o_less(o_less[2]), .o_equal(o_equal[2]),
        .o_taken(o_taken[2]), .o_illegal(o_illegal[2])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [3:0]  exp;   // {less, equal, taken, illegal}
    } vec_t;

    vec_t vecs [13];

    function automatic logic [3:0] flags(input int k);
        return {o_less[k], o_equal[k], o_taken[k], o_illegal[k]};
    endfunction

    function automatic logic [3:0] golden(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic eq, lt, tk, il;
        eq = (a == b);
        lt = f[1] ? (a < b) : ($signed(a) < $signed(b));
        il = (f == 3'b010) || (f == 3'b011);
        case (f)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = lt;
            3'b101, 3'b111: tk = !lt;
            default:        tk = 1'b0;
        endcase
        return {lt, eq, tk, il};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready0();
        int wt = 0;
        while (!o_ready[0] && wt < 100) begin
            @(posedge clk); #1; wt++;
        end
    endtask

    // Issues one request to the CHUNK=8 DUT, scrambles inputs after acceptance,
    // and returns the number of edges from handshake to o_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, output int lat);
        wait_ready0();
        rs1 = a; rs2 = b; f3 = f; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; rs1 = ~a; rs2 = $urandom; f3 = ~f;
        lat = 1;
        while (!o_valid[0] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 4'b1010};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 4'b0000};
        vecs[2]  = '{32'h1234_5678, 32'h1234_5678, 3'b000, 4'b0110};
        vecs[3]  = '{32'h1234_5678, 32'h1234_5678, 3'b001, 4'b0100};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 3'b101, 4'b1000};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 3'b010, 4'b0101};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0001, 3'b111, 4'b1000};
        vecs[7]  = '{32'h0000_0001, 32'h0000_0000, 3'b110, 4'b0000};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 4'b0000};
        vecs[9]  = '{32'h0000_0005, 32'h0000_0005, 3'b101, 4'b0110};
        vecs[10] = '{32'h0000_0005, 32'h0000_0003, 3'b011, 4'b0001};
        vecs[11] = '{32'h0000_0000, 32'h0000_0001, 3'b001, 4'b1010};
        vecs[12] = '{32'h8000_0000, 32'h0000_0000, 3'b000, 4'b1000};

        rst = 1'b1; valid = 1'b0; rdy_in = 1'b1; rs1 = '0; rs2 = '0; f3 = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready_%0d", k), 32'(o_ready[k]), 32'd1);
            check($sformatf("reset_valid_%0d", k), 32'(o_valid[k]), 32'd0);
            check($sformatf("reset_flags_%0d", k), 32'(flags(k)), 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].f, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_flags", i), 32'(flags(0)), 32'(vecs[i].exp));
            @(posedge clk); #1;
            check($sformatf("vec%0d_back_idle", i), 32'({o_ready[0], o_valid[0]}), 32'b10);
        end

        // Result held with i_ready low while i_valid stays high.
        wait_ready0();
        rdy_in = 1'b0; rs1 = 32'hFFFF_FFFF; rs2 = 32'h0000_0001; f3 = 3'b100; valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!o_valid[0] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("hold_latency", 32'(lat), 32'd5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold_c%0d_state", c), 32'({o_valid[0], o_ready[0]}), 32'b10);
            check($sformatf("hold_c%0d_flags", c), 32'(flags(0)), 32'b1010);
        end
        rdy_in = 1'b1;
        @(posedge clk); #1;
        check("release_idle", 32'({o_valid[0], o_ready[0]}), 32'b01);
        @(posedge clk); #1;
        check("reaccept_after_idle", 32'(o_ready[0]), 32'd0);
        valid = 1'b0;
        lat = 1;
        while (!o_valid[0] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("reaccept_flags", 32'(flags(0)), 32'b1010);
        @(posedge clk); #1;

        // Reset during the third BUSY cycle discards the request.
        wait_ready0();
        rs1 = 32'd5; rs2 = 32'd3; f3 = 3'b000; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_valid", 32'(o_valid[0]), 32'd0);
        check("midreset_ready", 32'(o_ready[0]), 32'd1);
        check("midreset_flags", 32'(flags(0)), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (o_valid[0]) seen++;
        end
        check("midreset_no_result", 32'(seen), 32'd0);
        run_op(32'h0000_0000, 32'h0000_0001, 3'b110, lat);
        check("postreset_latency", 32'(lat), 32'd5);
        check("postreset_flags", 32'(flags(0)), 32'b1010);
        @(posedge clk); #1;

        // Random operands across all three chunk widths.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            logic [2:0]  f;
            logic        got [3];
            logic [3:0]  res [3];
            int          glat [3];
            int          cyc;
            int          wt;
            a = $urandom;
            b = (n % 4 == 0) ? a : ((n % 4 == 1) ? (a ^ (32'h1 << $urandom_range(0, 31))) : $urandom);
            f = 3'($urandom_range(0, 7));
            wt = 0;
            while (!(o_ready[0] && o_ready[1] && o_ready[2]) && wt < 100) begin
                @(posedge clk); #1; wt++;
            end
            rs1 = a; rs2 = b; f3 = f; valid = 1'b1;
            @(posedge clk); #1;
            valid = 1'b0; rs1 = $urandom; rs2 = $urandom; f3 = ~f;
            for (int k = 0; k < 3; k++) begin
                got[k] = 1'b0; res[k] = '0; glat[k] = 0;
            end
            cyc = 0;
            while (!(got[0] && got[1] && got[2]) && cyc < 80) begin
                @(posedge clk); #1; cyc++;
                for (int k = 0; k < 3; k++) begin
                    if (o_valid[k] && !got[k]) begin
                        got[k] = 1'b1; res[k] = flags(k); glat[k] = cyc + 1;
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rand%0d_dut%0d_done", n, k), 32'(got[k]), 32'd1);
                check($sformatf("rand%0d_dut%0d_latency", n, k), 32'(glat[k]), 32'(NCH[k] + 1));
                check($sformatf("rand%0d_dut%0d_flags a=%h b=%h f=%b", n, k, a, b, f),
                      32'(res[k]), 32'(golden(a, b, f)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brc_iter.md
BRC_ITER -- requirements
Module: brc_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be a multiple of CHUNK, CHUNK >= 1; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have ports i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_valid  input  1  request valid.
REQ-006 SHALL have ports o_ready  output  1  block can accept a request.
REQ-007 SHALL have ports i_rs1_data, i_rs2_data  input  WIDTH  operands.
REQ-008 SHALL have ports i_funct3  input  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-009 SHALL have ports o_valid  output  1  result valid.
REQ-010 SHALL have ports i_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports o_less, o_equal, o_taken, o_illegal  output  1 each  registered result flags.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; o_ready = 1 only in IDLE, o_valid = 1 only in DONE.
REQ-013 IDLE: on i_valid & o_ready, SHALL latch both operands and i_funct3, clear carry to 1, clear difference-accumulator, clear chunk counter, go to BUSY.
REQ-014 BUSY: each cycle k (0..NCHUNK-1) SHALL compute chunk k (LSB chunk first) of rs1 + ~rs2 + carry, store carry-out, OR chunk k of (rs1 ^ rs2) into the difference-accumulator.
REQ-015 After chunk NCHUNK-1 SHALL go to DONE with flags registered; request-accept to o_valid latency SHALL be exactly NCHUNK+1 cycles.
REQ-016 o_equal SHALL be 1 iff rs1 == rs2 (difference-accumulator zero).
REQ-017 Unsigned (funct3[1]=1): o_less SHALL equal ~final carry.
REQ-018 Signed (funct3[1]=0): o_less SHALL equal diff[WIDTH-1] ^ overflow, where overflow = (rs1[MSB] ^ rs2[MSB]) & (diff[MSB] ^ rs1[MSB]).
REQ-019 o_taken SHALL be: BEQ equal; BNE ~equal; BLT/BLTU less; BGE/BGEU ~less.
REQ-020 funct3 010/011 SHALL set o_illegal = 1, o_taken = 0; o_less/o_equal still computed.
REQ-021 DONE: outputs SHALL hold stable while i_ready = 0; on i_ready = 1 SHALL return to IDLE next cycle (no same-cycle re-accept).
REQ-022 i_valid in BUSY or DONE SHALL be ignored; operand input changes after acceptance SHALL not affect the result.
REQ-023 NCHUNK = 1 SHALL work (one BUSY cycle); counter width SHALL be max(1, clog2(NCHUNK)).

Reset
REQ-024 i_reset = 1 at a rising edge SHALL force IDLE, o_valid = 0, o_less = o_equal = o_taken = o_illegal = 0, counter = 0, from any state including mid-BUSY; an in-flight request SHALL be discarded with no result.
REQ-025 o_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-026 A shared package brc_pkg SHALL hold the funct3 branch-type enum and the FSM state enum.
REQ-027 A single sub-module brc_chunk_sub (CHUNK-bit a + ~b + cin, outputs diff and cout) SHALL be instantiated once and reused each BUSY cycle.
REQ-028 The implementation SHALL use no combinational path from inputs to o_valid or result flags.

Verification (WIDTH=32, CHUNK=8)
REQ-029 BLT rs1=0xFFFFFFFF, rs2=0x00000001 -> o_less=1, o_taken=1, o_valid exactly 5 cycles after accept; BLTU same operands -> o_less=0, o_taken=0.
REQ-030 BEQ rs1=rs2=0x12345678 -> o_equal=1, o_taken=1; BNE same -> o_taken=0; BGE rs1=0x80000000, rs2=0x00000001 -> o_less=1 (overflow path), o_taken=0.
REQ-031 Result with i_ready held 0 for 3 cycles, i_valid=1 throughout -> flags stable, o_ready=0, no second request accepted until IDLE.
REQ-032 i_reset pulsed in 3rd BUSY cycle -> next cycle IDLE, o_valid=0, all flags 0, o_ready=1; fresh BLTU 0x00000000 vs 0x00000001 -> o_taken=1.
REQ-033 funct3=010, rs1=rs2=0 -> o_illegal=1, o_taken=0, o_equal=1.
REQ-034 Random operands and funct3 x 10k, also with CHUNK=1 and CHUNK=32 -> flags match a golden comparison model.
